// File: rtl/uart_receiver_if.sv
// UART receiver output bundle: received byte, status pulses and the
// downstream FIFO back-pressure flag.
interface uart_receiver_if #(
    parameter int SIZE_DATA = 8
);
    logic                 i_fifo_full;
    logic [SIZE_DATA-1:0] o_rx_data;
    logic                 o_rx_done;
    logic                 o_frame_err;
    logic                 o_overrun;

    modport master (
        input  i_fifo_full,
        output o_rx_data,
        output o_rx_done,
        output o_frame_err,
        output o_overrun
    );

    modport slave (
        output i_fifo_full,
        input  o_rx_data,
        input  o_rx_done,
        input  o_frame_err,
        input  o_overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/stop decoding with overrun and
// framing-error pulses. Optional macro UART_RX_MAJORITY_EN: 3-sample vote.
module uart_receiver #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16,
    parameter int MID_SAMPLE  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stick,
    input  logic             i_rx_serial,
    uart_receiver_if.master  rx_if
);
    localparam int TW = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
    localparam int BW = $clog2(SIZE_DATA + 1);
    localparam logic [TW-1:0] MID_LAST = TW'(MID_SAMPLE - 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(OVER_SAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(SIZE_DATA - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [SIZE_DATA-1:0] shreg_q, shreg_d;
    logic [SIZE_DATA-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 sync1_q, rx_s_q, rx_prev_q;
    logic                 rx_s;
    logic                 sample;
    logic [SIZE_DATA:0]   shift_ext;

    assign rx_s = rx_s_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_rx_serial;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;
    logic [2:0] win;

    assign win    = {hist_q, rx_s};
    assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

    // Keep the two previous stick samples; the live value completes the window
    always_comb begin
        hist_d = hist_q;
        if (i_stick) hist_d = {hist_q[0], rx_s};
    end

    // History register, idle-high after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hist_q <= 2'b11;
        else          hist_q <= hist_d;
    end
`else
    assign sample = rx_s;
`endif

    assign shift_ext = {sample, shreg_q};

    // Next-state and output pulse logic for the frame decoder
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (i_stick) begin
                    if (tick_q == MID_LAST) begin
                        tick_d  = '0;
                        state_d = sample ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_stick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shreg_d = shift_ext[SIZE_DATA:1];
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_stick) begin
                    if (tick_q == BIT_LAST) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        idx_d   = '0;
                        if (!sample) begin
                            ferr_d = 1'b1;
                        end else if (rx_if.i_fifo_full) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d = shreg_q;
                            done_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoder state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.o_rx_data   = data_q;
    assign rx_if.o_rx_done   = done_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: serial frames driven from a
// byte-level model, output pulses checked by an independent monitor.
module tb_uart_receiver;
    localparam int DIV = 8;
    localparam int OS  = 16;
    localparam int MID = 8;
    localparam int LAT = MID + 9 * OS;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic stick;
    logic rx;
    longint stick_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    logic [7:0] last_data;

    uart_receiver_if #(.SIZE_DATA(8)) rx_if ();

    uart_receiver #(
        .SIZE_DATA(8),
        .OVER_SAMPLE(OS),
        .MID_SAMPLE(MID)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_stick(stick),
        .i_rx_serial(rx),
        .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    initial begin
        stick = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk);
            stick = 1'b1;
            @(negedge clk);
            stick = 1'b0;
        end
    end

    always @(posedge clk) if (stick) stick_cnt <= stick_cnt + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic wait_sticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!stick) @(posedge clk);
        end
        #1;
    endtask

    // Monitor: pops one expectation per observed output pulse
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] ev;
        logic [2:0] want;
        ev = {rx_if.o_rx_done, rx_if.o_frame_err, rx_if.o_overrun};
        if (rst_n && ev != 3'b000) begin
            if (prev_pulse) begin
                n_tests++;
                n_fail++;
                $display("FAIL back_to_back: pulses %b on consecutive cycles", ev);
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got %b, expected none", ev);
            end else begin
                e = exp_q.pop_front();
                want = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
                chk("pulse_kind", longint'(ev), longint'(want));
                chk("rx_data", longint'(rx_if.o_rx_data), longint'(e.data));
                chk("latency_sticks", stick_cnt - e.start, LAT);
            end
        end
        prev_pulse = rst_n && (ev != 3'b000);
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_val,
                              input bit full, input int glitch_bit,
                              input logic [7:0] exp_byte);
        exp_t e;
        e.kind = !stop_val ? 1 : (full ? 2 : 0);
        e.data = (e.kind == 0) ? exp_byte : last_data;
        if (e.kind == 0) last_data = exp_byte;
        rx_if.i_fifo_full = full;
        wait_sticks(1);
        rx = 1'b0;
        e.start = stick_cnt;
        exp_q.push_back(e);
        wait_sticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                wait_sticks(MID - 1);
                rx = ~b[i];
                wait_sticks(1);
                rx = b[i];
                wait_sticks(OS - MID);
            end else begin
                wait_sticks(OS);
            end
        end
        rx = stop_val;
        wait_sticks(OS);
        rx = 1'b1;
        rx_if.i_fifo_full = 1'b0;
        wait_sticks(4 + int'($urandom_range(0, 20)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g_exp;
        rst_n = 1'b0;
        rx = 1'b1;
        rx_if.i_fifo_full = 1'b0;
        last_data = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_rx_data", longint'(rx_if.o_rx_data), 0);
        chk("reset_rx_done", longint'(rx_if.o_rx_done), 0);
        chk("reset_frame_err", longint'(rx_if.o_frame_err), 0);
        chk("reset_overrun", longint'(rx_if.o_overrun), 0);
        rst_n = 1'b1;
        wait_sticks(20);

        send_frame(8'h55, 1'b1, 1'b0, -1, 8'h55);
        send_frame(8'hA3, 1'b0, 1'b0, -1, 8'hA3);
        send_frame(8'h3C, 1'b1, 1'b0, -1, 8'h3C);

        rx = 1'b0;
        wait_sticks(4);
        rx = 1'b1;
        wait_sticks(40);

        send_frame(8'h7E, 1'b1, 1'b1, -1, 8'h7E);

        wait_sticks(1);
        rx = 1'b0;
        wait_sticks(OS);
        rx = 1'b1;
        wait_sticks(4 * OS + MID);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_data = 8'h00;
        @(negedge clk);
        chk("abort_rx_data", longint'(rx_if.o_rx_data), 0);
        wait_sticks(6 * OS);
        send_frame(8'h12, 1'b1, 1'b0, -1, 8'h12);

`ifdef UART_RX_MAJORITY_EN
        g_exp = 8'h00;
`else
        g_exp = 8'h04;
`endif
        send_frame(8'h00, 1'b1, 1'b0, 2, g_exp);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] rb;
            bit sv;
            bit fl;
            rb = 8'($urandom);
            sv = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 3) == 0);
            send_frame(rb, sv, fl, -1, rb);
        end

        wait_sticks(40);
        chk("queue_drain", longint'(exp_q.size()), 0);
        chk("final_rx_data", longint'(rx_if.o_rx_data), longint'(last_data));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter OVER_SAMPLE, default 16, stick pulses per bit.
REQ-003 SHALL have parameter MID_SAMPLE, default 8, stick pulses from start edge to start-bit centre.
REQ-004 SHALL have ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stick  in  1  baud oversample tick, one i_clk cycle wide, from baud_generator.
- i_rx_serial  in  1  serial line, idle high, asynchronous to i_clk.
- i_fifo_full  in  1  downstream FIFO cannot accept a byte.
- o_rx_data  out  SIZE_DATA  last received byte.
- o_rx_done  out  1  one-cycle pulse, o_rx_data valid and to be written.
- o_frame_err  out  1  one-cycle pulse, stop bit sampled low.
- o_overrun  out  1  one-cycle pulse, byte dropped because i_fifo_full.

Function
REQ-005 SHALL pass i_rx_serial through a 2-flop synchronizer, both flops resetting to 1; all decisions use the synchronized value (rx_s).
REQ-006 SHALL implement FSM states IDLE, START, DATA, STOP; tick counter counts i_stick pulses only, 0..OVER_SAMPLE-1.
REQ-007 IDLE: on 1->0 transition of rx_s -> START, tick counter 0, bit index 0.
REQ-008 START: on the stick where counter == MID_SAMPLE-1, sample bit (REQ-014); 0 -> DATA with counter 0; 1 -> IDLE (false start, no output pulse).
REQ-009 DATA: on the stick where counter == OVER_SAMPLE-1, sample bit, shift into data register LSB first, counter 0, bit index +1; after SIZE_DATA-th bit -> STOP.
REQ-010 STOP: on the stick where counter == OVER_SAMPLE-1, sample bit, -> IDLE in the same cycle.
REQ-011 Stop sampled 1 and i_fifo_full == 0: o_rx_data <= shift register, o_rx_done = 1 for exactly the next cycle.
REQ-012 Stop sampled 1 and i_fifo_full == 1: o_rx_data unchanged, o_overrun pulses one cycle, no o_rx_done.
REQ-013 Stop sampled 0: o_frame_err pulses one cycle, o_rx_data unchanged, no o_rx_done; IDLE then requires rx_s to return to 1 before detecting a new start edge.
REQ-014 Counter advances only on i_stick; i_rx_serial changes between sticks have no effect except through samples taken on sticks.
REQ-015 o_rx_done, o_frame_err, o_overrun SHALL be mutually exclusive and never asserted on consecutive cycles for one frame.
REQ-016 Latency: o_rx_done asserts one cycle after the stick at which the stop bit is sampled, i.e. MID_SAMPLE + (SIZE_DATA+1)*OVER_SAMPLE sticks after the start edge (152 sticks at defaults).

Reset
REQ-017 On i_rst_n low, state SHALL be IDLE, counter 0, bit index 0, shift register 0, o_rx_data 0, o_rx_done 0, o_frame_err 0, o_overrun 0, synchronizer flops 1, majority history 3'b111.
REQ-018 Reset mid-frame SHALL abort the frame with no output pulse; after release, reception resumes at the next 1->0 edge.

Configuration
REQ-019 Macro UART_RX_MAJORITY_EN defined: a 3-bit history of rx_s captured on every stick; bit sample = majority of the current and previous two stick values.
REQ-020 Macro UART_RX_MAJORITY_EN undefined: bit sample = rx_s at the sampling stick only; history register absent; all else identical.

Verification (50 MHz clock, baud_generator BAUDRATE_VALUE 325, defaults)
REQ-021 Loopback from Transmitter sending 8'b01010101 -> exactly one o_rx_done, o_rx_data = 8'h55, 152 sticks after the start edge.
REQ-022 Frame 8'hA3 with stop bit forced 0 -> single o_frame_err pulse, no o_rx_done, o_rx_data keeps previous value, next valid 8'h3C received correctly.
REQ-023 Low glitch of 4 stick periods on idle line -> return to IDLE, no pulse on any output.
REQ-024 i_fifo_full = 1 during frame 8'h7E -> o_overrun pulse, no o_rx_done, o_rx_data unchanged.
REQ-025 i_rst_n asserted during bit 4 of 8'hFF, released, then 8'h12 sent -> no output for the aborted frame, o_rx_data = 8'h12.
REQ-026 One-stick-wide inverted glitch at the centre of bit 2 of 8'h00 -> 8'h00 with UART_RX_MAJORITY_EN, 8'h04 without.
